// File: rtl/alu_pkg.sv
// Shared types for the pipelined EX-stage ALU: opcode and FSM state encodings.
package alu_pkg;

   // Operation select, fully decoded over the 3-bit ALUControl field
   typedef enum logic [2:0] {
      ALU_ADD  = 3'd0,
      ALU_SUB  = 3'd1,
      ALU_AND  = 3'd2,
      ALU_OR   = 3'd3,
      ALU_XOR  = 3'd4,
      ALU_SLT  = 3'd5,
      ALU_SLTU = 3'd6,
      ALU_MUL  = 3'd7
   } alu_op_t;

   // Control FSM: idle/accepting, or busy iterating a multiply
   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_MUL  = 1'b1
   } alu_state_t;

endpackage

// File: rtl/alu_addsub.sv
// Shared adder/subtractor used by ADD, SUB, SLT and SLTU.
// Subtraction is A + ~B + 1, so carry=1 means "no borrow" (A >= B unsigned).
module alu_addsub
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             sub,
   output logic [WIDTH-1:0] sum,
   output logic             carry,
   output logic             overflow
);

   logic [WIDTH-1:0] bEff;
   logic [WIDTH:0]   fullSum;

   // One wide add with the invert-and-increment trick for subtraction;
   // signed overflow is when both addends agree in sign but the sum does not
   always_comb begin
      bEff     = sub ? ~B : B;
      fullSum  = {1'b0, A} + {1'b0, bEff} + {{WIDTH{1'b0}}, sub};
      sum      = fullSum[WIDTH-1:0];
      carry    = fullSum[WIDTH];
      overflow = (A[WIDTH-1] == bEff[WIDTH-1]) && (fullSum[WIDTH-1] != A[WIDTH-1]);
   end

endmodule

// File: rtl/alu_pipe.sv
// Registered EX-stage ALU with valid/ready handshakes on both sides.
// Single-cycle ops produce a result one cycle after acceptance; MUL runs an
// iterative shift-add over WIDTH cycles while in_ready is held low.
module alu_pipe
   import alu_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter bit MUL_EN = 1'b1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] BussA,
   input  logic [WIDTH-1:0] BussB,
   input  logic [2:0]       ALUControl,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] Output,
   output logic             zero,
   output logic             overflow,
   output logic             CarryOut,
   output logic             negative
);

   localparam int CW = $clog2(WIDTH);

   alu_state_t       state_q, state_d;
   logic             outValid_q, outValid_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             zero_q, zero_d;
   logic             ovf_q, ovf_d;
   logic             carry_q, carry_d;
   logic             neg_q, neg_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] mcand_q, mcand_d;
   logic [WIDTH-1:0] mplier_q, mplier_d;
   logic [CW-1:0]    cnt_q, cnt_d;

   alu_op_t          op;
   logic             accept;
   logic             subSel;
   logic [WIDTH-1:0] asSum;
   logic             asCarry;
   logic             asOvf;
   logic [WIDTH-1:0] aluRes;
   logic             aluOvf;
   logic             aluCarry;
   logic [WIDTH-1:0] mulSum;
   logic             loadResult;

   assign op       = alu_op_t'(ALUControl);
   assign in_ready = (state_q == ST_IDLE) && (!outValid_q || out_ready);
   assign accept   = in_valid && in_ready;
   assign subSel   = (op != ALU_ADD);
   assign mulSum   = acc_q + (mplier_q[0] ? mcand_q : '0);

   alu_addsub #(.WIDTH(WIDTH)) uAddSub (
      .A        (BussA),
      .B        (BussB),
      .sub      (subSel),
      .sum      (asSum),
      .carry    (asCarry),
      .overflow (asOvf)
   );

   // Single-cycle result and arithmetic flags for the op currently on the inputs;
   // SLT uses N^V so it stays correct when A-B overflows
   always_comb begin
      aluRes   = '0;
      aluOvf   = 1'b0;
      aluCarry = 1'b0;
      case (op)
         ALU_ADD, ALU_SUB: begin
            aluRes   = asSum;
            aluOvf   = asOvf;
            aluCarry = asCarry;
         end
         ALU_AND:  aluRes = BussA & BussB;
         ALU_OR:   aluRes = BussA | BussB;
         ALU_XOR:  aluRes = BussA ^ BussB;
         ALU_SLT:  aluRes = {{(WIDTH-1){1'b0}}, asSum[WIDTH-1] ^ asOvf};
         ALU_SLTU: aluRes = {{(WIDTH-1){1'b0}}, ~asCarry};
         ALU_MUL:  aluRes = '0;
      endcase
   end

   // Next-state logic: output slot drain, accept of a new op, and multiply stepping
   always_comb begin
      state_d    = state_q;
      outValid_d = outValid_q;
      result_d   = result_q;
      zero_d     = zero_q;
      ovf_d      = ovf_q;
      carry_d    = carry_q;
      neg_d      = neg_q;
      acc_d      = acc_q;
      mcand_d    = mcand_q;
      mplier_d   = mplier_q;
      cnt_d      = cnt_q;
      loadResult = 1'b0;

      if (outValid_q && out_ready) begin
         outValid_d = 1'b0;
      end

      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               if (MUL_EN && (op == ALU_MUL)) begin
                  state_d  = ST_MUL;
                  acc_d    = '0;
                  mcand_d  = BussA;
                  mplier_d = BussB;
                  cnt_d    = CW'(WIDTH - 1);
               end else begin
                  result_d   = aluRes;
                  ovf_d      = aluOvf;
                  carry_d    = aluCarry;
                  outValid_d = 1'b1;
                  loadResult = 1'b1;
               end
            end
         end
         ST_MUL: begin
            acc_d    = mulSum;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q - CW'(1);
            if (cnt_q == '0) begin
               state_d    = ST_IDLE;
               result_d   = mulSum;
               ovf_d      = 1'b0;
               carry_d    = 1'b0;
               outValid_d = 1'b1;
               loadResult = 1'b1;
            end
         end
      endcase

      if (loadResult) begin
         zero_d = (result_d == '0);
         neg_d  = result_d[WIDTH-1];
      end
   end

   // State and output registers; reset aborts any multiply in flight
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         outValid_q <= 1'b0;
         result_q   <= '0;
         zero_q     <= 1'b0;
         ovf_q      <= 1'b0;
         carry_q    <= 1'b0;
         neg_q      <= 1'b0;
         acc_q      <= '0;
         mcand_q    <= '0;
         mplier_q   <= '0;
         cnt_q      <= '0;
      end else begin
         state_q    <= state_d;
         outValid_q <= outValid_d;
         result_q   <= result_d;
         zero_q     <= zero_d;
         ovf_q      <= ovf_d;
         carry_q    <= carry_d;
         neg_q      <= neg_d;
         acc_q      <= acc_d;
         mcand_q    <= mcand_d;
         mplier_q   <= mplier_d;
         cnt_q      <= cnt_d;
      end
   end

   assign out_valid = outValid_q;
   assign Output    = result_q;
   assign zero      = zero_q;
   assign overflow  = ovf_q;
   assign CarryOut  = carry_q;
   assign negative  = neg_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Directed testbench for alu_pipe: a 32-bit instance checked through a
// scoreboard of modelled results, plus an 8-bit instance for a short MUL.
module tb_alu_pipe;

   logic        clk;
   logic        reset;

   logic        inValid;
   logic        inReady;
   logic [31:0] bussA;
   logic [31:0] bussB;
   logic [2:0]  aluControl;
   logic        outValid;
   logic        outReady;
   logic [31:0] outData;
   logic        zeroFlag;
   logic        ovfFlag;
   logic        carryFlag;
   logic        negFlag;

   logic        inValid8;
   logic        inReady8;
   logic [7:0]  bussA8;
   logic [7:0]  bussB8;
   logic [2:0]  aluControl8;
   logic        outValid8;
   logic        outReady8;
   logic [7:0]  outData8;
   logic        zeroFlag8;
   logic        ovfFlag8;
   logic        carryFlag8;
   logic        negFlag8;

   int          errors = 0;
   int          checks = 0;
   logic [35:0] sb[$];

   alu_pipe #(.WIDTH(32), .MUL_EN(1'b1)) dut (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (inValid),
      .in_ready   (inReady),
      .BussA      (bussA),
      .BussB      (bussB),
      .ALUControl (aluControl),
      .out_valid  (outValid),
      .out_ready  (outReady),
      .Output     (outData),
      .zero       (zeroFlag),
      .overflow   (ovfFlag),
      .CarryOut   (carryFlag),
      .negative   (negFlag)
   );

   alu_pipe #(.WIDTH(8), .MUL_EN(1'b1)) dut8 (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (inValid8),
      .in_ready   (inReady8),
      .BussA      (bussA8),
      .BussB      (bussB8),
      .ALUControl (aluControl8),
      .out_valid  (outValid8),
      .out_ready  (outReady8),
      .Output     (outData8),
      .zero       (zeroFlag8),
      .overflow   (ovfFlag8),
      .CarryOut   (carryFlag8),
      .negative   (negFlag8)
   );

   // Free-running clock, 10 ns period
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Absolute time limit so the run can never hang
   initial begin
      #500000;
      $display("[TB] FAIL watchdog observed=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Reference model: {result, zero, overflow, carry, negative} for WIDTH=32
   function automatic logic [35:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      logic [31:0] r;
      logic        v;
      logic        c;
      longint      sa;
      longint      sb2;
      longint      s;
      logic [32:0] w;
      logic [63:0] p;
      sa  = longint'($signed(a));
      sb2 = longint'($signed(b));
      r   = '0;
      v   = 1'b0;
      c   = 1'b0;
      case (op)
         3'd0: begin
            w = {1'b0, a} + {1'b0, b};
            r = w[31:0];
            c = w[32];
            s = sa + sb2;
            v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
         end
         3'd1: begin
            r = a - b;
            c = (a >= b);
            s = sa - sb2;
            v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
         end
         3'd2: r = a & b;
         3'd3: r = a | b;
         3'd4: r = a ^ b;
         3'd5: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         3'd6: r = (a < b) ? 32'd1 : 32'd0;
         default: begin
            p = 64'(a) * 64'(b);
            r = p[31:0];
         end
      endcase
      return {r, (r == 32'd0), v, c, r[31]};
   endfunction

   // Single comparison point: counts it and reports any difference
   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // Present one op on the 32-bit instance, wait (bounded) for acceptance, record its expected result
   task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, output int waited);
      inValid    = 1'b1;
      aluControl = op;
      bussA      = a;
      bussB      = b;
      waited     = 0;
      @(negedge clk);
      while (!inReady && waited < 200) begin
         waited++;
         @(negedge clk);
      end
      checkOutput("accept", 64'(inReady), 64'd1);
      if (inReady) begin
         sb.push_back(model(op, a, b));
      end
      @(posedge clk);
      #1;
      inValid = 1'b0;
   endtask

   // Wait (bounded) for every expected result to be consumed
   task automatic drainScoreboard();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
      checkOutput("drain", 64'(sb.size()), 64'd0);
   endtask

   // Scoreboard consumer: every transfer on the output side must match the oldest expectation
   always @(negedge clk) begin
      if (!reset && outValid && outReady) begin
         checks++;
         assert (sb.size() > 0) else begin
            errors++;
            $error("[TB] FAIL spurious_result observed=%h expected=no_result", outData);
         end
         if (sb.size() > 0) begin
            checkOutput("result", 64'({outData, zeroFlag, ovfFlag, carryFlag, negFlag}), 64'(sb.pop_front()));
         end
      end
   end

   // Directed sequence
   initial begin
      int w;
      reset       = 1'b1;
      inValid     = 1'b0;
      bussA       = '0;
      bussB       = '0;
      aluControl  = '0;
      outReady    = 1'b1;
      inValid8    = 1'b0;
      bussA8      = '0;
      bussB8      = '0;
      aluControl8 = '0;
      outReady8   = 1'b1;

      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput("reset_state", 64'({outData, zeroFlag, ovfFlag, carryFlag, negFlag, outValid, inReady}),
                  64'({32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1}));
      @(posedge clk);
      #1;
      reset = 1'b0;

      // ADD overflow into the sign bit, latency of one cycle
      applyStimulus(3'd0, 32'h7FFF_FFFF, 32'h0000_0001, w);
      checkOutput("add_latency", 64'(outValid), 64'd1);
      drainScoreboard();

      // SUB, SLT and SLTU across the signed boundary, then a carry/zero ADD
      applyStimulus(3'd1, 32'h8000_0000, 32'h0000_0001, w);
      applyStimulus(3'd5, 32'h8000_0000, 32'h0000_0001, w);
      applyStimulus(3'd6, 32'h8000_0000, 32'h0000_0001, w);
      applyStimulus(3'd0, 32'hFFFF_FFFF, 32'h0000_0001, w);
      applyStimulus(3'd5, 32'h0000_0005, 32'hFFFF_FFFB, w);
      applyStimulus(3'd6, 32'h0000_0005, 32'hFFFF_FFFB, w);
      applyStimulus(3'd1, 32'h0000_0003, 32'h0000_0007, w);
      drainScoreboard();

      // Back-to-back logic ops: no wait between accepts
      applyStimulus(3'd4, 32'hA5A5_F00F, 32'h0FF0_1234, w);
      applyStimulus(3'd2, 32'hDEAD_BEEF, 32'hFFFF_0000, w);
      checkOutput("b2b_ready_and", 64'(w), 64'd0);
      applyStimulus(3'd3, 32'h1200_0034, 32'h0056_7800, w);
      checkOutput("b2b_ready_or", 64'(w), 64'd0);
      drainScoreboard();

      // MUL: busy for WIDTH cycles, result exactly WIDTH cycles after accept
      applyStimulus(3'd7, 32'h0000_1234, 32'h0000_0105, w);
      checkOutput("mul_busy_0", 64'({outValid, inReady}), 64'd0);
      for (int i = 1; i < 32; i++) begin
         @(posedge clk);
         #1;
         checkOutput("mul_busy", 64'({outValid, inReady}), 64'd0);
      end
      @(posedge clk);
      #1;
      checkOutput("mul_done", 64'(outValid), 64'd1);
      drainScoreboard();

      applyStimulus(3'd7, 32'hFFFF_FFFF, 32'h0000_0003, w);
      drainScoreboard();

      // Backpressure: result held stable while the consumer stalls
      outReady = 1'b0;
      applyStimulus(3'd0, 32'h7FFF_FFFF, 32'h0000_0001, w);
      repeat (5) begin
         @(negedge clk);
         checkOutput("bp_hold", 64'({outValid, inReady, outData, zeroFlag, ovfFlag, carryFlag, negFlag}),
                     64'({1'b1, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b1}));
      end
      @(posedge clk);
      #1;
      outReady = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("bp_drained", 64'({outValid, inReady}), 64'({1'b0, 1'b1}));
      drainScoreboard();

      // Reset in the middle of a MUL discards it
      applyStimulus(3'd7, 32'h0000_1234, 32'h0000_0105, w);
      repeat (9) @(posedge clk);
      #1;
      reset = 1'b1;
      sb.delete();
      @(negedge clk);
      checkOutput("mid_reset", 64'({outValid, inReady}), 64'({1'b0, 1'b1}));
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      checkOutput("post_reset", 64'({outValid, inReady}), 64'({1'b0, 1'b1}));
      repeat (40) @(posedge clk);
      #1;
      checkOutput("no_late_result", 64'(outValid), 64'd0);

      // 8-bit instance: 0x0F * 0x11 takes 8 cycles
      inValid8    = 1'b1;
      aluControl8 = 3'd7;
      bussA8      = 8'h0F;
      bussB8      = 8'h11;
      @(negedge clk);
      checkOutput("w8_ready", 64'(inReady8), 64'd1);
      @(posedge clk);
      #1;
      inValid8 = 1'b0;
      checkOutput("w8_busy_0", 64'({outValid8, inReady8}), 64'd0);
      for (int i = 1; i < 8; i++) begin
         @(posedge clk);
         #1;
         checkOutput("w8_busy", 64'(outValid8), 64'd0);
      end
      @(posedge clk);
      #1;
      checkOutput("w8_mul", 64'({outValid8, outData8, zeroFlag8, ovfFlag8, carryFlag8, negFlag8}),
                  64'({1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1}));

      checkOutput("sb_empty", 64'(sb.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
